constraint_eval_seq: RTL

//  Sequential, table-programmable successor to the fixed combinational split_N constraint checkers.

---
 rtl/constraint_eval_seq.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/constraint_eval_seq.sv
// constraint_eval_seq
// Sequential, table-programmable constraint checker. A candidate assignment of
// NUM_VARS variables is latched, then one table entry is evaluated per cycle and
// the verdict (satisfied / first failing entry) is offered on a valid/ready port.
// Optional feature macro: CEVAL_FULL_SCAN_EN -- disables early exit, evaluates
// every entry and adds the res_fmask output (one bit per failing enabled entry).
module constraint_eval_seq #(
  parameter int NUM_VARS = 20,
  parameter int VAR_W    = 32,
  parameter int NUM_CONS = 20,
  localparam int IDX_W   = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1,
  localparam int CIDX_W  = (NUM_CONS > 1) ? $clog2(NUM_CONS) : 1,
  localparam int CFG_W   = 6 + 2 * IDX_W + VAR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [CIDX_W-1:0]         cfg_addr,
  input  logic [CFG_W-1:0]          cfg_data,
  output logic                      cfg_err,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_VARS*VAR_W-1:0] in_vars,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      res_sat,
  output logic [CIDX_W-1:0]         res_fidx
`ifdef CEVAL_FULL_SCAN_EN
  ,
  output logic [NUM_CONS-1:0]       res_fmask
`endif
);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  localparam logic [IDX_W:0]      NV_LIM    = (IDX_W + 1)'(NUM_VARS);
  localparam logic [CIDX_W:0]     NC_LIM    = (CIDX_W + 1)'(NUM_CONS);
  localparam logic [CIDX_W-1:0]   LAST_IDX  = CIDX_W'(NUM_CONS - 1);
  localparam logic [VAR_W-1:0]    SHIFT_LIM = VAR_W'(VAR_W);

  state_t              state_reg, state_next;
  logic [CIDX_W-1:0]   cnt_reg;
  logic [VAR_W-1:0]    vars_reg   [NUM_VARS];
  logic [VAR_W-1:0]    in_var_arr [NUM_VARS];
  logic [CFG_W-2:0]    tbl_mem    [NUM_CONS];
  logic [NUM_CONS-1:0] en_reg;
  logic                cfg_err_reg;
  logic                res_sat_reg;
  logic [CIDX_W-1:0]   res_fidx_reg;

  logic                cfg_ok;
  logic [CFG_W-2:0]    ent_body;
  logic [2:0]          ent_op;
  logic                ent_inv, ent_use_k;
  logic [IDX_W-1:0]    ent_idx_a, ent_idx_b;
  logic [VAR_W-1:0]    ent_k;
  logic [VAR_W-1:0]    op_a, op_b, op_sum, op_diff;
  logic                op_r;
  logic                cond_ok;

  // Unpack the flat candidate bus into one word per variable.
  generate
    for (genvar gi = 0; gi < NUM_VARS; gi++) begin : g_unpack
      assign in_var_arr[gi] = in_vars[gi*VAR_W +: VAR_W];
    end
  endgenerate

  // Table is only writable while idle and for in-range addresses.
  assign cfg_ok = cfg_we && (state_reg == IDLE) && ({1'b0, cfg_addr} < NC_LIM);

  // Entry body storage (everything except the enable bit); no reset needed.
  always_ff @(posedge clk) begin
    if (cfg_ok) begin
      tbl_mem[cfg_addr] <= cfg_data[CFG_W-2:0];
    end
  end

  // Enable bits live in flops so reset can disable the whole table at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_reg      <= '0;
      cfg_err_reg <= 1'b0;
    end else begin
      cfg_err_reg <= cfg_we && !cfg_ok;
      if (cfg_ok) begin
        en_reg[cfg_addr] <= cfg_data[CFG_W-1];
      end
    end
  end

  // Capture the candidate when it is accepted.
  always_ff @(posedge clk) begin
    if ((state_reg == IDLE) && in_valid) begin
      vars_reg <= in_var_arr;
    end
  end

  // Field decode of the entry currently being evaluated.
  assign ent_body  = tbl_mem[cnt_reg];
  assign ent_op    = ent_body[CFG_W-2 -: 3];
  assign ent_inv   = ent_body[CFG_W-5];
  assign ent_use_k = ent_body[CFG_W-6];
  assign ent_idx_a = ent_body[VAR_W+2*IDX_W-1 -: IDX_W];
  assign ent_idx_b = ent_body[VAR_W+IDX_W-1 -: IDX_W];
  assign ent_k     = ent_body[VAR_W-1:0];

  // Operand selection and the eight operators; out-of-range indices read as zero.
  always_comb begin
    op_a    = ({1'b0, ent_idx_a} < NV_LIM) ? vars_reg[ent_idx_a] : '0;
    op_b    = ent_use_k ? ent_k :
              (({1'b0, ent_idx_b} < NV_LIM) ? vars_reg[ent_idx_b] : '0);
    op_sum  = op_a + op_b;
    op_diff = op_a - op_b;
    op_r    = 1'b0;
    case (ent_op)
      3'd0:    op_r = |op_sum;
      3'd1:    op_r = |op_diff;
      3'd2:    op_r = |(op_a & op_b);
      3'd3:    op_r = |(op_a ^ op_b);
      3'd4:    op_r = (op_a != op_b);
      3'd5:    op_r = (|op_a) || (|op_b);
      3'd6:    op_r = (|op_a) && (|op_b);
      default: op_r = (op_b < SHIFT_LIM) && (|(op_a << op_b));
    endcase
    // Disabled entries always pass.
    cond_ok = en_reg[cnt_reg] ? (op_r ^ ent_inv) : 1'b1;
  end

`ifdef CEVAL_FULL_SCAN_EN
  logic [NUM_CONS-1:0] fmask_reg;
  logic [NUM_CONS-1:0] fmask_next;
  logic [CIDX_W-1:0]   first_fail;

  // Accumulate the failure bit of the current entry into the mask.
  generate
    for (genvar gi = 0; gi < NUM_CONS; gi++) begin : g_fmask
      assign fmask_next[gi] = fmask_reg[gi] || (!cond_ok && (cnt_reg == CIDX_W'(gi)));
    end
  endgenerate

  // Lowest failing entry of the completed mask.
  always_comb begin
    first_fail = '0;
    for (int i = NUM_CONS - 1; i >= 0; i--) begin
      if (fmask_next[i]) first_fail = CIDX_W'(i);
    end
  end

  assign res_fmask = fmask_reg;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic: accept, walk the table, hold the result until taken.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid) state_next = EVAL;
`ifdef CEVAL_FULL_SCAN_EN
      EVAL: if (cnt_reg == LAST_IDX) state_next = DONE;
`else
      EVAL: if (!cond_ok || (cnt_reg == LAST_IDX)) state_next = DONE;
`endif
      DONE: if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Entry counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg      <= '0;
      res_sat_reg  <= 1'b0;
      res_fidx_reg <= '0;
`ifdef CEVAL_FULL_SCAN_EN
      fmask_reg    <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            cnt_reg <= '0;
`ifdef CEVAL_FULL_SCAN_EN
            fmask_reg <= '0;
`endif
          end
        end
        EVAL: begin
`ifdef CEVAL_FULL_SCAN_EN
          fmask_reg <= fmask_next;
          if (cnt_reg == LAST_IDX) begin
            res_sat_reg  <= ~|fmask_next;
            res_fidx_reg <= first_fail;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
`else
          if (!cond_ok) begin
            res_sat_reg  <= 1'b0;
            res_fidx_reg <= cnt_reg;
          end else if (cnt_reg == LAST_IDX) begin
            res_sat_reg  <= 1'b1;
            res_fidx_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign res_valid = (state_reg == DONE);
  assign res_sat   = res_sat_reg;
  assign res_fidx  = res_fidx_reg;
  assign cfg_err   = cfg_err_reg;

endmodule
